// File: rtl/sample_framer.sv
//------------------------------------------------------------------------------
// Module      : sample_framer
// Description : Streaming framer for the windowing/FFT front end. Accepts
//               16-bit signed samples on a valid/ready stream and presents
//               overlapping FRAME_LEN-sample frames, advancing HOP samples
//               per frame, as a stable parallel array with valid/ready.
// Options     : PREEMPH_EN - apply first-order pre-emphasis
//               (y = x - 0.97*xp) to every accepted sample on the accept path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_framer #(
  parameter int FRAME_LEN = 306,
  parameter int HOP       = 122
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] frame [FRAME_LEN],
  output logic               frame_valid,
  input  logic               frame_ready
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [15:0]    buf_q [FRAME_LEN];
  logic signed [15:0]    buf_d [FRAME_LEN];
  logic signed [15:0]    frame_q [FRAME_LEN];
  logic                  frame_valid_q, frame_valid_d;

  logic                  completing_slot_w;
  logic                  accept_w;
  logic                  complete_w;
  logic signed [15:0]    sample_w;

`ifdef PREEMPH_EN
  logic signed [15:0]    xp_q;
  logic signed [31:0]    prod_w;
  logic signed [17:0]    scaled_w;
  logic signed [17:0]    diff_w;

  // Scale the previous raw sample by 31785/32768 and subtract at 18 bits.
  assign prod_w   = 32'sd31785 * $signed(32'(xp_q));
  assign scaled_w = 18'(prod_w >>> 15);
  assign diff_w   = $signed({{2{in_sample[15]}}, in_sample}) - scaled_w;

  // Saturate the 18-bit difference back into the 16-bit sample range.
  always_comb begin
    sample_w = diff_w[15:0];
    if (diff_w[17:15] != 3'b000 && diff_w[17:15] != 3'b111) begin
      sample_w = diff_w[17] ? 16'sh8000 : 16'sh7fff;
    end
  end

  // Previous raw sample; persists across frame boundaries, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      xp_q <= '0;
    end else if (accept_w) begin
      xp_q <= in_sample;
    end
  end
`else
  assign sample_w = in_sample;
`endif

  // A slot completes a frame when its accept closes the current phase.
  assign completing_slot_w = ((state_q == ST_FILL) && (cnt_q == CW'(FRAME_LEN - 1))) ||
                             ((state_q == ST_RUN)  && (cnt_q == CW'(HOP - 1)));

  // Only a completing sample is held off, and only while the old frame is unconsumed.
  assign in_ready   = !(completing_slot_w && frame_valid_q && !frame_ready);
  assign accept_w   = in_valid && in_ready;
  assign complete_w = accept_w && completing_slot_w;

  // Shifted buffer image: oldest drops out of index 0, new sample enters at the top.
  always_comb begin
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      buf_d[i] = buf_q[i + 1];
    end
    buf_d[FRAME_LEN - 1] = sample_w;
  end

  // Phase control: FILL gathers a full frame once, RUN gathers HOP per frame.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    if (accept_w) begin
      if (complete_w) begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (complete_w) begin
      frame_valid_d = 1'b1;
    end else if (frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  // State, counter and frame-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Shift buffer advances once per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept_w) begin
      buf_q <= buf_d;
    end
  end

  // Output frame snapshots the buffer, including the completing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        frame_q[i] <= '0;
      end
    end else if (complete_w) begin
      frame_q <= buf_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_framer.sv
//------------------------------------------------------------------------------
// Module      : tb_sample_framer
// Description : Self-checking bench for sample_framer. A predictor records
//               every accepted sample and queues the start index of each
//               frame the stream should produce; a monitor compares the
//               presented frame, frame_valid and in_ready against it.
// Options     : PREEMPH_EN - model applies the same pre-emphasis rule.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_framer;

  localparam int FRAME_LEN = 306;
  localparam int HOP       = 122;
  localparam int HIST_LEN  = 16384;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] in_sample = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] frame [FRAME_LEN];
  logic               frame_valid;
  logic               frame_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: samples accepted since the last reset, and queued frames.
  int hist [HIST_LEN];
  int n_acc = 0;
  int exp_q [$];
  bit armed = 1'b0;
`ifdef PREEMPH_EN
  int xp_m = 0;
`endif

  always #5 clk = ~clk;

  sample_framer #(
    .FRAME_LEN (FRAME_LEN),
    .HOP       (HOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  function automatic bit completes(int n);
    return (n >= FRAME_LEN) && (((n - FRAME_LEN) % HOP) == 0);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predictor: record each accepted sample, queue completed frames.
  always @(posedge clk) begin
    if (rst) begin
      n_acc = 0;
      exp_q.delete();
      armed = 1'b1;
`ifdef PREEMPH_EN
      xp_m = 0;
`endif
    end else if (armed && in_valid && in_ready) begin
`ifdef PREEMPH_EN
      begin
        int y;
        y = int'(in_sample) - ((31785 * xp_m) >>> 15);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        hist[n_acc] = y;
        xp_m = int'(in_sample);
      end
`else
      hist[n_acc] = int'(in_sample);
`endif
      n_acc++;
      if (completes(n_acc)) exp_q.push_back(n_acc - FRAME_LEN);
    end
  end

  // Monitor: compare DUT outputs with the reference away from the active edge.
  always @(negedge clk) begin
    if (armed && !rst) begin
      bit pend;
      pend = (exp_q.size() != 0);
      chk("frame_valid", int'(frame_valid), int'(pend));
      if (frame_valid && pend) begin
        int base;
        int bad_idx;
        base    = exp_q[0];
        bad_idx = -1;
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (bad_idx < 0 && int'(frame[i]) != hist[base + i]) bad_idx = i;
        end
        n_cmp++;
        if (bad_idx >= 0) begin
          n_bad++;
          $display("FAIL frame[%0d]: got %0d, expected %0d (t=%0t)", bad_idx,
                   int'(frame[bad_idx]), hist[base + bad_idx], $time);
        end
      end
      chk("in_ready", int'(in_ready),
          int'(!(completes(n_acc + 1) && pend && !frame_ready)));
      if (frame_valid && frame_ready && pend) void'(exp_q.pop_front());
    end
  end

  task automatic do_reset(int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(int v);
    bit ok;
    in_valid  = 1'b1;
    in_sample = 16'(v);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0, expected acceptance of %0d", v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(int cycles, bit with_rst);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      rst         = with_rst && ($urandom_range(0, 399) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_sample   = 16'($urandom);
      frame_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);

    // Fill: 1..306 with the consumer stalled.
    frame_ready = 1'b0;
    for (int v = 1; v <= FRAME_LEN; v++) send(v);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", int'(frame_valid), 1);
`ifndef PREEMPH_EN
    chk("t1_first", int'(frame[0]), 1);
    chk("t1_last", int'(frame[FRAME_LEN-1]), FRAME_LEN);
`endif
    @(posedge clk);
    #1;

    // Back-pressure: 121 more go in, the completing one stalls.
    for (int v = FRAME_LEN + 1; v < FRAME_LEN + HOP; v++) send(v);
    in_valid  = 1'b1;
    in_sample = 16'(FRAME_LEN + HOP);
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall", int'(in_ready), 0);
`ifndef PREEMPH_EN
      chk("t3_hold", int'(frame[0]), 1);
`endif
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    @(negedge clk);
    chk("t3_release", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", int'(frame_valid), 1);
`ifndef PREEMPH_EN
    chk("t4_first", int'(frame[0]), HOP + 1);
    chk("t4_last", int'(frame[FRAME_LEN-1]), FRAME_LEN + HOP);
`endif
    @(posedge clk);
    #1;

    // Hop with a free-running consumer.
    for (int v = FRAME_LEN + HOP + 1; v <= FRAME_LEN + 2 * HOP; v++) send(v);
    in_valid = 1'b0;

    run_random(3000, 1'b0);

    // Reset mid-fill discards all earlier data.
    do_reset(2);
    frame_ready = 1'b0;
    for (int v = 1; v <= 200; v++) send(v);
    do_reset(1);
    for (int v = 1000; v < 1000 + FRAME_LEN; v++) send(v);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", int'(frame_valid), 1);
`ifndef PREEMPH_EN
    chk("t5_first", int'(frame[0]), 1000);
    chk("t5_last", int'(frame[FRAME_LEN-1]), 1000 + FRAME_LEN - 1);
`endif
    @(posedge clk);
    #1;

`ifdef PREEMPH_EN
    do_reset(2);
    frame_ready = 1'b0;
    for (int k = 0; k < FRAME_LEN; k++) send(10000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_first", int'(frame[0]), 10000);
    chk("t6_second", int'(frame[1]), 300);
    chk("t6_last", int'(frame[FRAME_LEN-1]), 300);
    @(posedge clk);
    #1;
`endif

    do_reset(2);
    run_random(3000, 1'b1);

    // Drain whatever is pending.
    frame_ready = 1'b1;
    in_valid    = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", int'(frame_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
